// File: rtl/layer_seq_if.sv
// Handshake and bus bundle between a layer sequencer and its host/datapath.
//   start      host -> seq   run request
//   stall      host -> seq   datapath not ready, freezes accumulation stepping
//   busy       seq  -> host  sequencer not idle
//   done       seq  -> host  one-cycle layer-complete pulse
//   neuron_idx seq  -> host  current neuron / result slot
//   in_idx     seq  -> host  current input sample
//   w_addr     seq  -> host  weight memory address
//   acc_clr    seq  -> host  clear accumulator
//   acc_en     seq  -> host  accumulate input*weight
//   acc_last   seq  -> host  final accumulation of a neuron
//   out_we     seq  -> host  write accumulator result
// Modports: master = host side, slave = sequencer side.
interface layer_seq_if #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic              stall;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  neuron_idx;
    logic [IDX_W-1:0]  in_idx;
    logic [ADDR_W-1:0] w_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              acc_last;
    logic              out_we;

    modport master (
        output start, stall,
        input  busy, done, neuron_idx, in_idx, w_addr, acc_clr, acc_en, acc_last, out_we
    );

    modport slave (
        input  start, stall,
        output busy, done, neuron_idx, in_idx, w_addr, acc_clr, acc_en, acc_last, out_we
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected ANN layer. On start it walks every neuron: clear the
// accumulator, accumulate N_INPUTS products (stall freezes stepping), write the result, then
// pulses done once all neurons are written.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rstn  synchronous active-low reset; aborts any run without a done pulse
//   bus   layer_seq_if.slave: start/stall in; busy, done, indices, w_addr and MAC strobes out
module layer_seq_ctrl #(
    parameter int unsigned N_INPUTS  = 10,
    parameter int unsigned N_NEURONS = 32,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    layer_seq_if.slave    bus
);

    localparam logic [IDX_W-1:0]  LastIn     = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0]  LastNeuron = IDX_W'(N_NEURONS - 1);
    localparam logic [ADDR_W-1:0] AddrStride = ADDR_W'(N_INPUTS);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StWrite,
        StDone
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  neuron_q;
    logic [IDX_W-1:0]  in_q;
    // Running neuron_idx*N_INPUTS, avoids a multiplier on the address path.
    logic [ADDR_W-1:0] base_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            neuron_q <= '0;
            in_q     <= '0;
            base_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    in_q    <= '0;
                    state_q <= StAccum;
                end
                StAccum: begin
                    if (!bus.stall) begin
                        if (in_q != LastIn) begin
                            in_q <= in_q + 1'b1;
                        end else begin
                            in_q    <= '0;
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (neuron_q == LastNeuron) begin
                        state_q <= StDone;
                    end else begin
                        neuron_q <= neuron_q + 1'b1;
                        base_q   <= base_q + AddrStride;
                        state_q  <= StClear;
                    end
                end
                StDone: begin
                    neuron_q <= '0;
                    in_q     <= '0;
                    base_q   <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Moore decode; only acc_en/acc_last also see stall so a stalled cycle never accumulates.
    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.done       = (state_q == StDone);
        bus.acc_clr    = (state_q == StClear);
        bus.acc_en     = (state_q == StAccum) && !bus.stall;
        bus.acc_last   = (state_q == StAccum) && !bus.stall && (in_q == LastIn);
        bus.out_we     = (state_q == StWrite);
        bus.neuron_idx = neuron_q;
        bus.in_idx     = in_q;
        bus.w_addr     = base_q + ADDR_W'(in_q);
    end

endmodule
